// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - Shared types and constants for the matmul sequencer
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    READOUT,
    DONE
  } state_t;

  localparam int RES_IDX_W = 8;

  // One buffer-latency cycle, 2*(SIZE-1) diagonal skew, one MAC stage.
  function automatic int flush_cycles(input int size);
    return 2 * size;
  endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - Clear/feed/flush/readout sequencer for the systolic MAC array
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int KW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 op_rd_en,
  output logic [KW-1:0]        op_idx,
  input  logic [7:0]           op_a_data,
  input  logic [7:0]           op_b_data,
  output logic [7:0]           a_in,
  output logic [7:0]           b_in,
  output logic                 mult_en,
  output logic                 acc_en,
  output logic                 load_en,
  output logic [SIZE*SIZE-1:0] select,
  input  logic [31:0]          d_out,
  output logic [31:0]          res_data,
  output logic [RES_IDX_W-1:0] res_idx,
  output logic                 res_valid,
  input  logic                 res_ready
);

  localparam int                   SEL_W      = SIZE * SIZE;
  localparam logic [KW-1:0]        FLUSH_LAST = KW'(flush_cycles(SIZE) - 1);
  localparam logic [RES_IDX_W-1:0] R_LAST     = RES_IDX_W'(SIZE * SIZE - 1);

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        phase_q, phase_d;
  logic [RES_IDX_W-1:0] r_q, r_d;
  logic                 rd_d1_q, rd_d1_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 op_rd_en_q, op_rd_en_d;
  logic [KW-1:0]        op_idx_q, op_idx_d;
  logic                 mac_en_q, mac_en_d;
  logic                 load_en_q, load_en_d;
  logic                 res_valid_q, res_valid_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    phase_d = phase_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          phase_d = '0;
          r_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        phase_d = '0;
        state_d = (k_q != '0) ? FEED : READOUT;
      end
      FEED: begin
        if (phase_q == k_q - KW'(1)) begin
          phase_d = '0;
          state_d = FLUSH;
        end else begin
          phase_d = phase_q + KW'(1);
        end
      end
      FLUSH: begin
        if (phase_q == FLUSH_LAST) begin
          phase_d = '0;
          state_d = READOUT;
        end else begin
          phase_d = phase_q + KW'(1);
        end
      end
      READOUT: begin
        if (res_valid_q && res_ready) begin
          if (r_q == R_LAST) begin
            r_d     = '0;
            state_d = DONE;
          end else begin
            r_d = r_q + RES_IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort leaves the accumulators dirty; the next job's CLEAR wipes them.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      phase_d = '0;
      r_d     = '0;
    end

    // Outputs are registered from the next state so they align with it.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    load_en_d   = (state_d == CLEAR);
    op_rd_en_d  = (state_d == FEED);
    op_idx_d    = (state_d == FEED) ? phase_d : '0;
    mac_en_d    = (state_d == FEED) || (state_d == FLUSH);
    res_valid_d = (state_d == READOUT);
    rd_d1_d     = op_rd_en_q && mac_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      phase_q     <= '0;
      r_q         <= '0;
      rd_d1_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_rd_en_q  <= 1'b0;
      op_idx_q    <= '0;
      mac_en_q    <= 1'b0;
      load_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      phase_q     <= phase_d;
      r_q         <= r_d;
      rd_d1_q     <= rd_d1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_rd_en_q  <= op_rd_en_d;
      op_idx_q    <= op_idx_d;
      mac_en_q    <= mac_en_d;
      load_en_q   <= load_en_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign op_rd_en  = op_rd_en_q;
  assign op_idx    = op_idx_q;
  assign a_in      = rd_d1_q ? op_a_data : 8'h00;
  assign b_in      = rd_d1_q ? op_b_data : 8'h00;
  assign mult_en   = mac_en_q;
  assign acc_en    = mac_en_q;
  assign load_en   = load_en_q;
  assign select    = SEL_W'(r_q);
  assign res_idx   = r_q;
  assign res_valid = res_valid_q;
  assign res_data  = d_out;

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control sequencer for the SIZE×SIZE systolic MAC array. On a start command it clears the array accumulators, streams K operand pairs from the operand buffer into the array's `a_in`/`b_in` edge, and waits for the skewed wavefront to drain. It then reads all SIZE*SIZE accumulators out through the array's `select`/`d_out` mux as a valid/ready result stream. It sits between the command/operand buffers and the `array` instance and is the only driver of that array's enables.

## Interface
- `SIZE`, 4: array dimension; must match the array instance.
- `KW`, 8: width of the operand-count field.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a job; sampled only in IDLE.
- `k_len` in KW: operand pairs to stream, 0..2^KW-1; captured with `start`.
- `abort` in 1: synchronous cancel; returns to IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result handshake.
- `op_rd_en` out 1: operand buffer read strobe.
- `op_idx` out KW: operand index being read.
- `op_a_data`, `op_b_data` in 8: operand buffer data, valid the cycle after `op_rd_en`.
- `a_in`, `b_in` out 8: to array edge.
- `mult_en`, `acc_en`, `load_en` out 1: to array.
- `select` out SIZE*SIZE: binary accumulator index, zero-extended, to array.
- `d_out` in 32: from array.
- `res_data` out 32: result word; equals `d_out` combinationally.
- `res_idx` out 8: index of the current result (= `select`).
- `res_valid` out 1: result stream valid.
- `res_ready` in 1: result stream ready.

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, READOUT, DONE.
- IDLE: all outputs 0.
  - `start`=1 latches `k_len` into K and goes to CLEAR.
- CLEAR: one cycle, `load_en`=1, which zeroes every accumulator. `mult_en`=`acc_en`=0.
  - Next state is FEED if K>0, else READOUT. All-zero results are the legal answer for K=0.
- FEED: K cycles.
  - `op_rd_en`=1 and `op_idx` counts 0..K-1.
  - `mult_en`=`acc_en`=1.
- FLUSH: FLUSH_CYCLES = 2*SIZE cycles (8 for SIZE=4).
  - `mult_en`=`acc_en`=1 and `op_rd_en`=0.
  - This covers the 1-cycle buffer latency plus the 2*(SIZE-1) diagonal skew plus 1 MAC stage.
- Operand forwarding (FEED and FLUSH): `a_in`/`b_in` = `op_a_data`/`op_b_data` if `op_rd_en` was 1 in the previous cycle, else 0. Feeding zeros into the array is harmless.
- READOUT:
  - `res_valid`=1 and `select`=`res_idx`=r, with r starting at 0.
  - r advances on `res_valid && res_ready`.
  - The handshake at r=SIZE*SIZE-1 goes to DONE.
  - `res_valid` holds, and `res_data` stays stable, while `res_ready`=0.
- DONE: one cycle, `done`=1, then IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `abort`, in any non-IDLE state: next state is IDLE with all outputs 0. The array is not cleared; the next job's CLEAR handles that.
- Priority: `reset` > `abort` > normal transitions.

## Timing
- `start` high in cycle T:
  - CLEAR at T+1.
  - FEED at T+2..T+1+K.
  - FLUSH at T+2+K..T+1+K+2*SIZE.
  - First `res_valid` at T+2+K+2*SIZE.
- With `res_ready` held high:
  - `done` at T+2+K+2*SIZE+SIZE*SIZE.
  - For SIZE=4, K=3: `done` at T+29.
- `op_rd_en` and enables are registered outputs. `res_data` is the only combinational output.
- `reset` asserted in any cycle: next cycle is IDLE, all outputs 0, counters 0.

## Structure
- Package `matmul_pkg`:
  - `state_t` enum (IDLE, CLEAR, FEED, FLUSH, READOUT, DONE).
  - Localparam function `flush_cycles(SIZE)`.
  - Result index width constant.
- No sub-module:
  - One state register, one KW-bit phase counter (shared by FEED and FLUSH), one readout counter, one `rd_d1` flag.
  - Target 150-250 lines.

## Test plan
- Reset mid-FEED (K=10, `reset` at FEED cycle 4) -> next cycle all outputs 0, `busy`=0; a new `start` runs a full job cleanly.
- SIZE=4, K=4, A=B=identity operands from the buffer model, `res_ready`=1 -> CLEAR at T+1, 4 `op_rd_en` cycles, 8 FLUSH cycles, 16 results with identity values on the diagonal (indices 0,5,10,15) and 0 elsewhere, `done` at T+30.
- K=0 -> CLEAR then READOUT directly; 16 results all 0; `op_rd_en` never asserted; `done` at T+18.
- `res_ready` toggled 1,0,0,1,... during READOUT -> `res_idx` advances only on handshake cycles; `res_data`/`select` stable while stalled; exactly 16 handshakes before `done`.
- `abort` in READOUT at r=7 -> next cycle IDLE, `res_valid`=0, no `done` pulse. `start` asserted during FEED is ignored: exactly one `done` per accepted start.
